// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_pkg                                                     |
// | Description : Shared types and default bubble payloads for pipeline stages |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Fields a squashed MIPS slot carries so that downstream PC math stays sane
  localparam logic [31:0] BUBBLE_PC4 = 32'h0000_3004;
  localparam logic [31:0] BUBBLE_PC8 = 32'h0000_3008;
  localparam logic [31:0] BUBBLE_IR  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Up-counter that sticks at all-ones, cleared only by reset    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid                                              |
// | Description : Valid/ready pipeline register with two-entry skid buffer,    |
// |               flush, and saturating stall/bubble counters                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] w_main_d_nxt;
  logic [WIDTH-1:0] r_skid_d;
  logic [WIDTH-1:0] w_skid_d_nxt;
  logic             r_in_ready;
  logic             w_main_v;
  logic             w_in_fire;
  logic             w_out_fire;

  // Valid bits are implied by the state; main is occupied in ONE and FULL
  assign w_main_v   = (r_state != EMPTY);
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = w_main_v & out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_main_d_nxt = r_main_d;
    w_skid_d_nxt = r_skid_d;
    if (flush) begin
      w_state_nxt  = EMPTY;
      w_main_d_nxt = BUBBLE;
      w_skid_d_nxt = BUBBLE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt  = ONE;
            w_main_d_nxt = in_data;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_d_nxt = in_data;
          end else if (w_in_fire) begin
            w_state_nxt  = FULL;
            w_skid_d_nxt = in_data;
          end else if (w_out_fire) begin
            w_state_nxt  = EMPTY;
            w_main_d_nxt = BUBBLE;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt  = ONE;
            w_main_d_nxt = r_skid_d;
            w_skid_d_nxt = BUBBLE;
          end
        end
        default: begin
          w_state_nxt  = EMPTY;
          w_main_d_nxt = BUBBLE;
          w_skid_d_nxt = BUBBLE;
        end
      endcase
    end
  end

  // in_ready is computed from the next state so it leaves a flop, cutting
  // any combinational path from out_ready back upstream
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_main_d   <= BUBBLE;
      r_skid_d   <= BUBBLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main_d   <= w_main_d_nxt;
      r_skid_d   <= w_skid_d_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_v;
  assign out_data  = r_main_d;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_main_v & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_ready & ~w_main_v),
    .count (bubble_cnt)
  );

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register, the successor to the fixed per-stage registers (D→E, E→M, M→W). It carries an arbitrary-width payload under a valid/ready handshake and uses a two-entry skid buffer, so upstream `in_ready` is registered and throughput stays at one transfer per cycle. It supports flush (bubble insertion) and keeps saturating performance counters for stall and bubble cycles. It is instantiated once per pipeline boundary, with each stage's bundle (IR, PC4, PC8, operands, flags) packed into `in_data`.

## Interface
Parameters:
- `WIDTH`, 32 — payload width in bits.
- `BUBBLE`, {WIDTH{1'b0}} — payload value held in empty/flushed entries. A stage packs PC fields as 0x3004/0x3008 here.
- `CNT_W`, 16 — width of each performance counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held entries and drop this cycle's input.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept; driven directly from a flop.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is a real instruction.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  payload; equals BUBBLE whenever `out_valid`=0.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0.
- `bubble_cnt`  out  CNT_W  cycles with `out_ready`=1 and `out_valid`=0.

## Operation
- Storage: main entry (`main_v`, `main_d`) drives the outputs; skid entry (`skid_v`, `skid_d`) holds overflow.
- Handshake events: `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- States: EMPTY (no entries), ONE (main only), FULL (main + skid). `in_ready` = (state != FULL), registered.
- EMPTY:
  - `in_fire` → ONE, `main_d` <= `in_data`.
  - Otherwise stay in EMPTY.
- ONE:
  - `in_fire & out_fire` → ONE, `main_d` <= `in_data`.
  - `in_fire & !out_ready` → FULL, `skid_d` <= `in_data`.
  - `!in_fire & out_fire` → EMPTY, `main_d` <= BUBBLE.
  - Otherwise hold.
- FULL:
  - `out_fire` → ONE, `main_d` <= `skid_d`, `skid_d` <= BUBBLE.
  - Otherwise hold everything.
- Order is always preserved: skid contents never bypass main.
- Priority: `reset` > `flush` > handshake.
- `flush`: next state is EMPTY, both entries become BUBBLE, and `in_ready` becomes 1. An `in_fire` in the flush cycle is discarded. Upstream sees it as accepted, which matches branch-squash semantics.
- Counters:
  - Update on every non-reset cycle, including flush cycles.
  - Saturate at 2^CNT_W−1 with no wrap.
  - Cleared only by `reset`.
  - Counters are implemented without a carry-in mux.

## Timing
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `out_data`=BUBBLE, skid=BUBBLE, `stall_cnt`=0, `bubble_cnt`=0.
- Latency: 1 cycle from `in_fire` (in EMPTY or ONE with `out_fire`) to `out_valid`.
- Throughput: 1 payload per cycle with `out_ready` held at 1.
- `in_ready` deasserts the cycle after the entry into FULL. It reasserts the cycle after `out_fire` in FULL.
- No combinational path from `out_ready` to `in_ready`, nor from `in_*` to `out_*`.
- `reset` mid-operation drops both entries regardless of `flush`/handshake values that cycle.
- Simultaneous `flush` and `out_fire`: the output transfer completes this cycle, then the stage is empty.

## Structure
- Package `pipe_pkg`:
  - state enum {EMPTY, ONE, FULL}.
  - Default MIPS bubble constants (BUBBLE_PC4 = 32'h00003004, BUBBLE_PC8 = 32'h00003008, BUBBLE_IR = 0) for stage wrappers.
- Sub-module `sat_counter` (parameter CNT_W; ports `clk`, `reset`, `inc`, `count`), instantiated twice.

## Test plan
- Reset, then idle 3 cycles: `in_ready`=1, `out_valid`=0, `out_data`=BUBBLE; with `out_ready`=1, `bubble_cnt`=3.
- Streaming with `out_ready`=1: push 0x11, 0x22, 0x33 on consecutive cycles. Outputs appear one cycle later in order, and `in_ready` stays 1.
- Backpressure fill:
  - Stimulus: `out_ready`=0, push 0xA then 0xB.
  - State reaches FULL, and `in_ready`=0 the next cycle.
  - `out_data`=0xA is held and `stall_cnt` increments each cycle.
  - Release `out_ready`: outputs 0xA then 0xB.
- Flush in FULL with `in_valid`=1, `in_data`=0xC: the next cycle `out_valid`=0, `out_data`=BUBBLE, and `in_ready`=1. 0xC never appears.
- Saturation with CNT_W=3: hold stall for 10 cycles and `stall_cnt` stays at 7. Then assert `reset` in ONE: all outputs return to their reset values.
